// File: rtl/count_wrap_monitor.sv
// Watches a free-running 4-bit down counter, counts 0->15 wraps and raises an acknowledged alarm.
// Build with COUNT_WRAP_MON_SEQCHK_EN defined to add the decrement-by-one sequence checker (FAULT/seq_err).
module count_wrap_monitor #(
    parameter int WRAP_W      = 8,
    parameter int ALARM_WRAPS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        count_i,
    input  logic              mon_en_i,
    input  logic              alarm_ack_i,
    input  logic              err_clr_i,
    output logic              wrap_pulse_o,
    output logic [WRAP_W-1:0] wrap_cnt_o,
    output logic              alarm_o,
    output logic              seq_err_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ALARM = 2'b10,
        FAULT = 2'b11
    } state_t;

    localparam logic [WRAP_W-1:0] CNT_MAX  = '1;
    localparam logic [WRAP_W-1:0] ALARM_TH = WRAP_W'(ALARM_WRAPS);

    state_t            state_q, state_d;
    logic [3:0]        prev_q, prev_d;
    logic              prev_vld_q, prev_vld_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              is_wrap;
    logic              seq_bad;
    logic [WRAP_W-1:0] cnt_inc;

    assign is_wrap = prev_vld_q && (prev_q == 4'd0) && (count_i == 4'd15);
    assign cnt_inc = (wrap_cnt_q == CNT_MAX) ? wrap_cnt_q : wrap_cnt_q + WRAP_W'(1);

`ifdef COUNT_WRAP_MON_SEQCHK_EN
    assign seq_bad = prev_vld_q && (count_i != prev_q - 4'd1);
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign seq_bad        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        wrap_cnt_d   = wrap_cnt_q;
        wrap_pulse_d = 1'b0;
        if (state_q == FAULT) begin
`ifdef COUNT_WRAP_MON_SEQCHK_EN
            if (err_clr_i) begin
                state_d    = IDLE;
                prev_vld_d = 1'b0;
                wrap_cnt_d = '0;
            end
`endif
        end else if (!mon_en_i) begin
            // A gap invalidates the history so the next sample only resynchronises.
            prev_vld_d = 1'b0;
        end else begin
            prev_d       = count_i;
            prev_vld_d   = 1'b1;
            wrap_pulse_d = is_wrap;
            if (is_wrap) begin
                wrap_cnt_d = cnt_inc;
            end
            case (state_q)
                IDLE: state_d = TRACK;
                TRACK: begin
                    if (seq_bad) begin
                        state_d = FAULT;
                    end else if (is_wrap && (cnt_inc >= ALARM_TH)) begin
                        state_d = ALARM;
                    end
                end
                ALARM: begin
                    // Error beats ack; an ack coinciding with a wrap keeps that wrap counted.
                    if (seq_bad) begin
                        state_d = FAULT;
                    end else if (alarm_ack_i) begin
                        state_d    = TRACK;
                        wrap_cnt_d = is_wrap ? WRAP_W'(1) : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            prev_q       <= 4'd0;
            prev_vld_q   <= 1'b0;
            wrap_cnt_q   <= '0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            wrap_cnt_q   <= wrap_cnt_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign wrap_pulse_o = wrap_pulse_q;
    assign wrap_cnt_o   = wrap_cnt_q;
    assign alarm_o      = (state_q == ALARM);
    assign state_o      = state_q;
`ifdef COUNT_WRAP_MON_SEQCHK_EN
    assign seq_err_o    = (state_q == FAULT);
`else
    assign seq_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Bench for count_wrap_monitor: directed table, corner-case sequences and randomized run vs a reference model.
module tb_count_wrap_monitor;

    localparam int WW  = 8;
    localparam int AW  = 4;
    localparam int MAXWC = (1 << WW) - 1;
`ifdef COUNT_WRAP_MON_SEQCHK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    count_i = 4'd0;
    logic          mon_en_i = 1'b0;
    logic          alarm_ack_i = 1'b0;
    logic          err_clr_i = 1'b0;
    logic          wrap_pulse_o;
    logic [WW-1:0] wrap_cnt_o;
    logic          alarm_o;
    logic          seq_err_o;
    logic [1:0]    state_o;

    count_wrap_monitor #(.WRAP_W(WW), .ALARM_WRAPS(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .count_i      (count_i),
        .mon_en_i     (mon_en_i),
        .alarm_ack_i  (alarm_ack_i),
        .err_clr_i    (err_clr_i),
        .wrap_pulse_o (wrap_pulse_o),
        .wrap_cnt_o   (wrap_cnt_o),
        .alarm_o      (alarm_o),
        .seq_err_o    (seq_err_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: state as 0..3, counters as plain ints.
    int m_st, m_prev, m_wc;
    bit m_vld, m_pulse;

    int pulse_cyc[$];
    int pulse_wc[$];
    int pulse_alarm[$];

    typedef struct {
        logic [3:0] cnt;
        logic       en, ack, clr;
        logic [1:0] st;
        logic       pulse;
        logic [7:0] wc;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_prev = 0; m_wc = 0; m_vld = 0; m_pulse = 0;
    endtask

    task automatic model_step();
        bit wrap, bad;
        m_pulse = 0;
        if (m_st == 3) begin
            if (SEQ && err_clr_i) begin
                m_st = 0; m_vld = 0; m_wc = 0;
            end
        end else if (!mon_en_i) begin
            m_vld = 0;
        end else begin
            wrap = m_vld && (m_prev == 0) && (int'(count_i) == 15);
            bad  = SEQ && m_vld && (int'(count_i) != (m_prev + 15) % 16);
            m_prev = int'(count_i);
            m_vld  = 1;
            m_pulse = wrap;
            if (wrap && m_wc < MAXWC) m_wc = m_wc + 1;
            if (m_st == 0) m_st = 1;
            else if (bad) m_st = 3;
            else if (m_st == 1 && wrap && m_wc >= AW) m_st = 2;
            else if (m_st == 2 && alarm_ack_i) m_wc = wrap ? 1 : 0;
            if (m_st == 2 && !bad && alarm_ack_i) m_st = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".state"}, state_o, m_st);
        chk({tag, ".pulse"}, wrap_pulse_o, m_pulse);
        chk({tag, ".wrap_cnt"}, wrap_cnt_o, m_wc);
        chk({tag, ".alarm"}, alarm_o, (m_st == 2));
        chk({tag, ".seq_err"}, seq_err_o, (m_st == 3));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        compare_all(tag);
    endtask

    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) begin
            step("free");
            if (wrap_pulse_o) begin
                pulse_cyc.push_back(cyc);
                pulse_wc.push_back(int'(wrap_cnt_o));
                pulse_alarm.push_back(int'(alarm_o));
            end
            count_i = count_i - 4'd1;
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        model_reset();
        mon_en_i = 1'b0; alarm_ack_i = 1'b0; err_clr_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".state"}, state_o, 0);
        chk({tag, ".pulse"}, wrap_pulse_o, 0);
        chk({tag, ".wrap_cnt"}, wrap_cnt_o, 0);
        chk({tag, ".alarm"}, alarm_o, 0);
        chk({tag, ".seq_err"}, seq_err_o, 0);
    endtask

    initial begin
        tbl[0]  = '{4'd3,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd0};
        tbl[1]  = '{4'd2,  1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 8'd0};
        tbl[2]  = '{4'd1,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd0};
        tbl[3]  = '{4'd0,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd0};
        tbl[4]  = '{4'd15, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 8'd1};
        tbl[5]  = '{4'd14, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[6]  = '{4'd13, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[7]  = '{4'd2,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[8]  = '{4'd1,  1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[9]  = '{4'd0,  1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[10] = '{4'd15, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[11] = '{4'd14, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[12] = '{4'd13, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};
        tbl[13] = '{4'd12, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'd1};

        // Asynchronous reset asserted mid-cycle.
        #12;
        rst = 1'b0;
        #1;
        chk_reset_vals("por");
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Directed table: wrap, ignored ack/clr, enable gaps with resync.
        for (int i = 0; i < 14; i++) begin
            count_i = tbl[i].cnt; mon_en_i = tbl[i].en;
            alarm_ack_i = tbl[i].ack; err_clr_i = tbl[i].clr;
            step("tbl");
            chk($sformatf("tbl%0d.state", i), state_o, tbl[i].st);
            chk($sformatf("tbl%0d.pulse", i), wrap_pulse_o, tbl[i].pulse);
            chk($sformatf("tbl%0d.wrap_cnt", i), wrap_cnt_o, tbl[i].wc);
            chk($sformatf("tbl%0d.seq_err", i), seq_err_o, 0);
        end

        // Free-running from 15: four wraps 16 cycles apart, alarm on the fourth.
        do_reset();
        count_i = 4'd15; mon_en_i = 1'b1;
        pulse_cyc.delete(); pulse_wc.delete(); pulse_alarm.delete();
        run_free(70);
        chk("free.npulses", pulse_cyc.size(), 4);
        for (int i = 0; i < pulse_cyc.size(); i++) begin
            chk($sformatf("free.wc_at_pulse%0d", i), pulse_wc[i], i + 1);
            chk($sformatf("free.alarm_at_pulse%0d", i), pulse_alarm[i], (i == 3));
            if (i > 0) chk($sformatf("free.spacing%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 16);
        end
        chk("free.alarm_end", alarm_o, 1);
        alarm_ack_i = 1'b1;
        step("ack");
        chk("ack.alarm", alarm_o, 0);
        chk("ack.wrap_cnt", wrap_cnt_o, 0);
        chk("ack.state", state_o, 1);
        alarm_ack_i = 1'b0;
        count_i = count_i - 4'd1;

        // Back to ALARM, then ack on the very edge that samples 0->15.
        run_free(73);
        chk("simul.pre_alarm", alarm_o, 1);
        chk("simul.pre_count", count_i, 15);
        alarm_ack_i = 1'b1;
        step("simul");
        chk("simul.state", state_o, 1);
        chk("simul.wrap_cnt", wrap_cnt_o, 1);
        chk("simul.pulse", wrap_pulse_o, 1);
        alarm_ack_i = 1'b0;

        // Sequence error 9 -> 5.
        count_i = 4'd14;
        run_free(6);
        count_i = 4'd5;
        step("seq");
`ifdef COUNT_WRAP_MON_SEQCHK_EN
        chk("seq.err", seq_err_o, 1);
        chk("seq.state", state_o, 3);
        count_i = 4'd0;  step("fault0");
        count_i = 4'd15; step("fault15");
        chk("fault.pulse", wrap_pulse_o, 0);
        chk("fault.wrap_cnt", wrap_cnt_o, 1);
        chk("fault.state", state_o, 3);
        err_clr_i = 1'b1;
        step("clr");
        chk("clr.state", state_o, 0);
        chk("clr.wrap_cnt", wrap_cnt_o, 0);
        chk("clr.seq_err", seq_err_o, 0);
        err_clr_i = 1'b0;
`else
        chk("seq.err", seq_err_o, 0);
        chk("seq.state", state_o, 1);
        chk("seq.wrap_cnt", wrap_cnt_o, 1);
`endif

        // Reset while in ALARM with wrap_cnt=4.
        do_reset();
        count_i = 4'd15; mon_en_i = 1'b1;
        run_free(66);
        chk("rstalarm.pre_alarm", alarm_o, 1);
        chk("rstalarm.pre_wc", wrap_cnt_o, 4);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("rstalarm");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        count_i = 4'd7;
        step("resync");
        chk("resync.state", state_o, 1);

        // Randomized run against the model.
        do_reset();
        count_i = 4'($urandom_range(15));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 94) count_i = count_i - 4'd1;
            else count_i = 4'($urandom_range(15));
            mon_en_i    = ($urandom_range(99) < 95);
            alarm_ack_i = ($urandom_range(99) < 10);
            err_clr_i   = ($urandom_range(99) < 10);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_wrap_monitor.md
# count_wrap_monitor

Downstream consumer of the 4-bit free-running down counter. It samples the counter value every clock, detects each 0→15 wrap and counts wraps. It raises a level alarm with an acknowledge handshake after a programmable number of wraps. An optional sequence checker flags any sample that is not a decrement by one modulo 16.

## Interface
- WRAP_W, 8: width of wrap counter.
- ALARM_WRAPS, 4: wraps needed to raise alarm. Legal range 1..2^WRAP_W-1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- count  in  4  counter value from the down counter.
- mon_en  in  1  sample enable; when low, nothing is sampled.
- alarm_ack  in  1  alarm acknowledge; sampled only in ALARM.
- err_clr  in  1  clears FAULT and restarts monitoring.
- wrap_pulse  out  1  one-cycle pulse per detected wrap.
- wrap_cnt  out  WRAP_W  wraps since last reset, ack or clear; saturates at all-ones.
- alarm  out  1  high exactly while state is ALARM.
- seq_err  out  1  sticky; high exactly while state is FAULT.
- state  out  2  IDLE=00, TRACK=01, ALARM=10, FAULT=11.

## Operation
- Internal registers:
  - prev[3:0]: last sampled count.
  - prev_vld: prev holds a valid sample.
- Sample rule: at a clock edge with mon_en=1, compare count against prev, then load prev←count and set prev_vld←1.
- Wrap: prev_vld=1 and prev=0 and count=15. Produces wrap_pulse=1 for the following cycle and wrap_cnt+1 (saturating).
- Good step: count=(prev-1) mod 16, computed in 4-bit arithmetic. The 0→15 step is therefore both a good step and a wrap.
- mon_en=0:
  - No comparison is made, wrap_pulse=0, and prev_vld←0.
  - The next enabled sample resynchronises without a wrap or error check.
  - state, wrap_cnt and alarm are held.
- States:
  - IDLE: enter TRACK on the first enabled sample.
  - TRACK:
    - A wrap that brings wrap_cnt to ALARM_WRAPS (or already ≥ ALARM_WRAPS) → ALARM.
    - A sequence error → FAULT (checker compiled in).
  - ALARM:
    - Sampling, wrap detection and wrap counting continue.
    - alarm_ack=1 → TRACK with wrap_cnt←0.
    - If a wrap occurs on the same edge as the ack, the ack wins and wrap_cnt←1. wrap_pulse still fires.
    - A sequence error → FAULT; the error takes priority over the ack.
  - FAULT:
    - Sampling is frozen, wrap_pulse=0, and wrap_cnt is held.
    - err_clr=1 → IDLE with prev_vld←0 and wrap_cnt←0.
- err_clr outside FAULT has no effect. alarm_ack outside ALARM has no effect.
- If the upstream counter is reset on its own (for example 7→15), that is a sequence error, not a wrap.

## Timing
- Reset values: state=IDLE, prev=0, prev_vld=0, wrap_pulse=0, wrap_cnt=0, alarm=0, seq_err=0. Reset applies immediately on rst low, regardless of clk.
- All outputs are registered; none are combinational from inputs.
- Latency from count changing 0→15 (upstream edge j):
  - The monitor samples the change at edge j+1.
  - wrap_pulse, the wrap_cnt update, and entry to ALARM/alarm are all visible after edge j+1.
- Sequence error: state=FAULT and seq_err are visible after the edge that sampled the bad value.
- Ack: alarm falls after the first edge at which alarm_ack=1 is sampled in ALARM.
- Free-running counter, mon_en=1: one wrap every 16 cycles, so the alarm fires 16×ALARM_WRAPS cycles apart (minus the first-sync offset).
- Reset asserted mid-ALARM or mid-FAULT returns all outputs to their reset values asynchronously.

## Configuration
- COUNT_WRAP_MON_SEQCHK_EN defined:
  - The sequence checker is present.
  - Non-decrement samples cause FAULT and seq_err=1.
- COUNT_WRAP_MON_SEQCHK_EN undefined:
  - No checker logic is built. seq_err is tied to 0 and FAULT is unreachable.
  - Non-decrement samples just update prev.
  - err_clr is ignored.
  - Wrap detection is unchanged.

## Test plan
- Reset check: assert rst low mid-cycle → all outputs at their reset values immediately, state=00.
- Free-run alarm: ALARM_WRAPS=4, mon_en=1, counter free-running from 15.
  - 4 wrap_pulses, 16 cycles apart.
  - wrap_cnt counts 1..4 and alarm=1 after the 4th wrap.
  - Pulse ack → alarm=0, wrap_cnt=0, state=TRACK.
- Simultaneous ack and wrap: in ALARM, assert alarm_ack on the edge sampling 0→15 → state=TRACK, wrap_cnt=1, wrap_pulse=1.
- Sequence error, checker compiled in: force count 9→5 → seq_err=1 and state=FAULT the next cycle.
  - wrap_cnt stays frozen.
  - err_clr → IDLE, wrap_cnt=0.
  - Without the macro, the same stimulus gives seq_err=0 and state=TRACK.
- Enable gap: drop mon_en for 3 cycles spanning a counter wrap → no wrap_pulse and no seq_err. Counting resumes correctly on the next wrap.
- Reset mid-operation: assert rst while in ALARM with wrap_cnt=4 → alarm=0 and wrap_cnt=0 immediately. After release, the first sample gives IDLE→TRACK.
